serial_add_host: RTL
====================

SERIAL_ADD_HOST -- requirements
Module: serial_add_host

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to run one addition; sampled on rising clk.
REQ-005 op_a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 op_b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 sum_in  input  1  serial sum bit returned by the attached bit-serial adder (combinational from a, b, adder carry).
REQ-008 carry_in  input  1  carry-out bit returned by the attached adder.
REQ-009 a  output  1  serial operand A bit to adder, LSB first.
REQ-010 b  output  1  serial operand B bit to adder, LSB first.
REQ-011 adder_reset  output  1  synchronous clear to the adder's carry/shift state.
REQ-012 busy  output  1  high while a transaction is in progress.
REQ-013 done  output  1  one-cycle pulse, result valid.
REQ-014 result  output  WIDTH+1  parallel sum; bit WIDTH is the final carry.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE; all outputs registered.
REQ-016 In IDLE or DONE, start=1 SHALL latch op_a/op_b into shift registers and move to CLEAR; start in CLEAR or SHIFT SHALL be ignored.
REQ-017 CLEAR SHALL last exactly one cycle with adder_reset=1, a=0, b=0, busy=1.
REQ-018 SHIFT SHALL last exactly WIDTH cycles, indexed k=0..WIDTH-1; during cycle k, a=op_a[k], b=op_b[k], busy=1, adder_reset=0.
REQ-019 At the end of SHIFT cycle k, sum_in SHALL be stored into result[k].
REQ-020 At the end of SHIFT cycle WIDTH-1, carry_in SHALL be stored into result[WIDTH].
REQ-021 A bit counter of ceil(log2(WIDTH)) bits SHALL count SHIFT cycles; SHIFT exits to DONE when it reaches WIDTH-1, without wrap-around into another pass.
REQ-022 DONE SHALL last one cycle with done=1, busy=0, a=b=0; next state IDLE, or CLEAR if start=1.
REQ-023 Latency: start accepted at edge T -> done high in cycle T+WIDTH+2 (cycles counted from the first edge after acceptance).
REQ-024 result SHALL hold its value from DONE until the next accepted start; it is updated bit-by-bit only during SHIFT.
REQ-025 In IDLE: a=0, b=0, adder_reset=0, busy=0, done=0.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE and set a=0, b=0, busy=0, done=0, result=0, bit counter=0, error=0 (when present), adder_reset=1 for that cycle.
REQ-027 reset mid-CLEAR or mid-SHIFT SHALL abort the transaction with no done pulse; start coincident with reset SHALL be ignored.

Configuration
REQ-028 Macro SERIAL_ADD_HOST_CHECK_EN: when defined, the block SHALL compute op_a+op_b internally, add output error (1 bit), and set error=1 in the DONE cycle if result differs; error is cleared on the next accepted start.
REQ-029 Without SERIAL_ADD_HOST_CHECK_EN, port error and the internal adder SHALL not exist; all other behaviour is identical.

Verification
REQ-030 WIDTH=4, op_a=3, op_b=5, bench adder model -> a seq 1,1,0,0; b seq 1,0,1,0; done at T+6; result=5'b01000.
REQ-031 op_a=15, op_b=15 -> result=5'b11110 (carry captured into bit 4); op_a=0, op_b=0 -> result=0.
REQ-032 start held high continuously -> back-to-back transactions, CLEAR follows each DONE directly, start during SHIFT ignored.
REQ-033 reset asserted in SHIFT cycle k=2 -> IDLE next cycle, busy=0, result=0, no done pulse.
REQ-034 CHECK_EN defined, bench forces sum_in inverted at k=1 for 3+5 -> error=1 in DONE cycle; next correct run -> error=0.

Source files
------------

// File: rtl/serial_add_host_if.sv
// Bundle between the serial-add host, its requester and the attached bit-serial adder.
// Optional error flag exists only when SERIAL_ADD_HOST_CHECK_EN is defined.
interface serial_add_host_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sum_in;
    logic             carry_in;
    logic             a;
    logic             b;
    logic             adder_reset;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
`ifdef SERIAL_ADD_HOST_CHECK_EN
    logic             error;

    modport master (
        input  start, op_a, op_b, sum_in, carry_in,
        output a, b, adder_reset, busy, done, result, error
    );
    modport slave (
        output start, op_a, op_b, sum_in, carry_in,
        input  a, b, adder_reset, busy, done, result, error
    );
`else
    modport master (
        input  start, op_a, op_b, sum_in, carry_in,
        output a, b, adder_reset, busy, done, result
    );
    modport slave (
        output start, op_a, op_b, sum_in, carry_in,
        input  a, b, adder_reset, busy, done, result
    );
`endif
endinterface

// File: rtl/serial_add_host.sv
// Host that streams two operands LSB-first into an external bit-serial adder and rebuilds the sum.
// SERIAL_ADD_HOST_CHECK_EN adds an internal reference adder and the error output.
// IDLE wait start | CLEAR adder_reset pulse | SHIFT bit k=cnt | DONE one-cycle done pulse
module serial_add_host #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_add_host_if.master  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             a_q, a_d, b_q, b_d;
    logic             adr_q, adr_d, busy_q, busy_d, done_q, done_d;
`ifdef SERIAL_ADD_HOST_CHECK_EN
    logic [WIDTH:0]   ref_q, ref_d;
    logic             err_q, err_d;
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sha_d    = sha_q;
        shb_d    = shb_q;
        result_d = result_q;
        a_d      = 1'b0;
        b_d      = 1'b0;
        adr_d    = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SERIAL_ADD_HOST_CHECK_EN
        ref_d    = ref_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = CLEAR;
                    sha_d   = bus.op_a;
                    shb_d   = bus.op_b;
                    adr_d   = 1'b1;
                    busy_d  = 1'b1;
`ifdef SERIAL_ADD_HOST_CHECK_EN
                    ref_d   = (WIDTH+1)'(bus.op_a) + (WIDTH+1)'(bus.op_b);
                    err_d   = 1'b0;
`endif
                end
            end
            CLEAR: begin
                state_d = SHIFT;
                cnt_d   = '0;
                a_d     = sha_q[0];
                b_d     = shb_q[0];
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                busy_d  = 1'b1;
            end
            SHIFT: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i)) result_d[i] = bus.sum_in;
                end
                if (cnt_q == CW'(WIDTH-1)) begin
                    result_d[WIDTH] = bus.carry_in;
                    state_d         = DONE;
                    done_d          = 1'b1;
`ifdef SERIAL_ADD_HOST_CHECK_EN
                    err_d           = (result_d != ref_q);
`endif
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    a_d    = sha_q[0];
                    b_d    = shb_q[0];
                    sha_d  = sha_q >> 1;
                    shb_d  = shb_q >> 1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sha_q    <= '0;
            shb_q    <= '0;
            result_q <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            adr_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADD_HOST_CHECK_EN
            ref_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sha_q    <= sha_d;
            shb_q    <= shb_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            adr_q    <= adr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADD_HOST_CHECK_EN
            ref_q    <= ref_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.adder_reset = adr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
`ifdef SERIAL_ADD_HOST_CHECK_EN
    assign bus.error       = err_q;
`endif
endmodule
